// File: rtl/trap_sprite_mover_if.sv
// Pixel-side bus between the playfield renderer and a trap sprite:
// scan position in, sprite ROM address/data, per-pixel hit and colour out.
interface trap_sprite_mover_if #(
  parameter int ROM_AW = 11
);
  logic [9:0]        col;
  logic [9:0]        row;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_data;
  logic              is_obj;
  logic [11:0]       obj_rgb;

  modport master (output col, row, rom_data, input rom_addr, is_obj, obj_rgb);
  modport slave  (input col, row, rom_data, output rom_addr, is_obj, obj_rgb);
endinterface

// File: rtl/trap_sprite_mover.sv
// Triggered moving trap sprite: waits for the player to enter a trigger box,
// optionally delays, then slides in one direction until a travel limit or off screen.
//
// state   | meaning
// S_IDLE  | parked at initial position, watching the trigger box
// S_DELAY | triggered, counting update_en ticks before the first move
// S_MOVE  | stepping SPEED px per update_en tick
// S_DONE  | travel finished, frozen until restart
module trap_sprite_mover #(
  parameter int          INIT_X      = 0,
  parameter int          INIT_Y      = 0,
  parameter int          OBJ_W       = 22,
  parameter int          OBJ_H       = 24,
  parameter int          NUM_FRAMES  = 2,
  parameter int          ROM_AW      = 11,
  parameter int          TRIG_X0     = 0,
  parameter int          TRIG_X1     = 799,
  parameter int          TRIG_Y0     = 0,
  parameter int          TRIG_Y1     = 599,
  parameter int          DIR         = 1,
  parameter int          SPEED       = 1,
  parameter int          DELAY_TICKS = 0,
  parameter int          MAX_DIST    = 0,
  parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic                update_en,
  input  logic                toggle_en,
  input  logic [9:0]          kid_x,
  input  logic [9:0]          kid_y,
  output logic                triggered,
  trap_sprite_mover_if.slave  pix
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_MOVE, S_DONE} state_t;

  localparam logic signed [11:0] X0    = 12'(INIT_X);
  localparam logic signed [11:0] Y0    = 12'(INIT_Y);
  localparam logic signed [11:0] W_S   = 12'(OBJ_W);
  localparam logic signed [11:0] H_S   = 12'(OBJ_H);
  localparam logic signed [11:0] SCR_W = 12'sd800;
  localparam logic signed [11:0] SCR_H = 12'sd600;
  localparam logic signed [12:0] W13   = 13'(OBJ_W);
  localparam logic signed [12:0] H13   = 13'(OBJ_H);
  localparam logic [10:0]        MAXD  = 11'(MAX_DIST);
  localparam logic [3:0]         SPD   = 4'(SPEED);
  localparam logic [7:0]         DLY   = 8'(DELAY_TICKS);
  localparam logic [2:0]         LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [9:0]         TX0 = 10'(TRIG_X0);
  localparam logic [9:0]         TX1 = 10'(TRIG_X1);
  localparam logic [9:0]         TY0 = 10'(TRIG_Y0);
  localparam logic [9:0]         TY1 = 10'(TRIG_Y1);
  localparam logic [ROM_AW-1:0]  W_A  = ROM_AW'(OBJ_W);
  localparam logic [ROM_AW-1:0]  FS_A = ROM_AW'(OBJ_W * OBJ_H);

  state_t             state_q, state_nx;
  logic signed [11:0] pos_x_q, pos_x_nx, pos_y_q, pos_y_nx;
  logic signed [11:0] mv_x, mv_y, step_s;
  logic [10:0]        dist_q, dist_nx, remain, step;
  logic [7:0]         cnt_q, cnt_nx;
  logic [2:0]         frame_q, frame_nx;
  logic               kid_in, off_screen, hit_max, in_box, in_box_d;
  logic signed [12:0] dx, dy;

  assign kid_in = (kid_x >= TX0) && (kid_x <= TX1) && (kid_y >= TY0) && (kid_y <= TY1);

  // Last step is clipped so the trap lands exactly on the travel limit.
  always_comb begin
    remain = MAXD - dist_q;
    step   = {7'd0, SPD};
    if ((MAXD != 11'd0) && (remain < step)) step = remain;
    step_s = $signed({1'b0, step});
    mv_x = pos_x_q;
    mv_y = pos_y_q;
    case (DIR)
      0:       mv_y = pos_y_q - step_s;
      1:       mv_y = pos_y_q + step_s;
      2:       mv_x = pos_x_q - step_s;
      default: mv_x = pos_x_q + step_s;
    endcase
    off_screen = (mv_x >= SCR_W) || (mv_x + W_S <= 12'sd0) ||
                 (mv_y >= SCR_H) || (mv_y + H_S <= 12'sd0);
    hit_max    = (MAXD != 11'd0) && (dist_q + step == MAXD);
  end

  always_comb begin
    state_nx = state_q;
    pos_x_nx = pos_x_q;
    pos_y_nx = pos_y_q;
    dist_nx  = dist_q;
    cnt_nx   = cnt_q;
    frame_nx = frame_q;
    if (toggle_en) frame_nx = (frame_q == LAST_FRAME) ? 3'd0 : frame_q + 3'd1;
    case (state_q)
      S_IDLE: if (kid_in) begin
        state_nx = S_DELAY;
        cnt_nx   = 8'd0;
      end
      S_DELAY: begin
        if (cnt_q == DLY) state_nx = S_MOVE;
        else if (update_en) cnt_nx = cnt_q + 8'd1;
      end
      S_MOVE: if (update_en) begin
        pos_x_nx = mv_x;
        pos_y_nx = mv_y;
        dist_nx  = dist_q + step;
        if (hit_max || off_screen) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (restart) begin
      state_nx = S_IDLE;
      pos_x_nx = X0;
      pos_y_nx = Y0;
      dist_nx  = 11'd0;
      cnt_nx   = 8'd0;
      frame_nx = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_x_q <= X0;
      pos_y_q <= Y0;
      dist_q  <= 11'd0;
      cnt_q   <= 8'd0;
      frame_q <= 3'd0;
    end else begin
      state_q <= state_nx;
      pos_x_q <= pos_x_nx;
      pos_y_q <= pos_y_nx;
      dist_q  <= dist_nx;
      cnt_q   <= cnt_nx;
      frame_q <= frame_nx;
    end
  end

  assign triggered = (state_q != S_IDLE);

  // Offsets are signed so a sprite hanging off the top/left edge still draws its visible part.
  assign dx = $signed({3'b000, pix.col}) - $signed({pos_x_q[11], pos_x_q});
  assign dy = $signed({3'b000, pix.row}) - $signed({pos_y_q[11], pos_y_q});
  assign in_box = (dx >= 13'sd0) && (dx < W13) && (dy >= 13'sd0) && (dy < H13);

  assign pix.rom_addr = in_box ? (ROM_AW'(unsigned'(dx)) + ROM_AW'(unsigned'(dy)) * W_A +
                                  ROM_AW'(frame_q) * FS_A) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       in_box_d <= 1'b0;
    else if (restart) in_box_d <= 1'b0;
    else              in_box_d <= in_box;
  end

  assign pix.is_obj  = in_box_d && (pix.rom_data != TRANSPARENT);
  assign pix.obj_rgb = pix.is_obj ? pix.rom_data : 12'h000;

endmodule

// File: tb/tb_trap_sprite_mover.sv
// Three trap variants (down/delay, right/limited, up/off-top) sharing stimulus;
// pixel results go through an expected-value queue checked one clock after each probe.
module tb_trap_sprite_mover;
  logic       clk = 1'b0;
  logic       rst_n, restart, update_en, toggle_en;
  logic [9:0] kid_x, kid_y, col, row;
  logic [2:0] triggered;

  always #5 clk = ~clk;

  trap_sprite_mover_if #(.ROM_AW(11)) b0 ();
  trap_sprite_mover_if #(.ROM_AW(11)) b1 ();
  trap_sprite_mover_if #(.ROM_AW(11)) b2 ();

  function automatic logic [11:0] rom_val(input logic [10:0] a);
    if (a == 11'd0) return 12'hF00;
    if ((a % 11'd7) == 11'd3) return 12'hFFF;
    return {1'b0, a};
  endfunction

  assign b0.col = col; assign b0.row = row;
  assign b1.col = col; assign b1.row = row;
  assign b2.col = col; assign b2.row = row;
  always @(posedge clk) begin
    b0.rom_data <= rom_val(b0.rom_addr);
    b1.rom_data <= rom_val(b1.rom_addr);
    b2.rom_data <= rom_val(b2.rom_addr);
  end

  logic [10:0] addr_o [3];
  logic        is_o   [3];
  logic [11:0] rgb_o  [3];
  assign addr_o[0] = b0.rom_addr; assign is_o[0] = b0.is_obj; assign rgb_o[0] = b0.obj_rgb;
  assign addr_o[1] = b1.rom_addr; assign is_o[1] = b1.is_obj; assign rgb_o[1] = b1.obj_rgb;
  assign addr_o[2] = b2.rom_addr; assign is_o[2] = b2.is_obj; assign rgb_o[2] = b2.obj_rgb;

  trap_sprite_mover #(.INIT_X(100), .INIT_Y(0), .NUM_FRAMES(3), .ROM_AW(11),
    .TRIG_X0(0), .TRIG_X1(99), .TRIG_Y0(0), .TRIG_Y1(99),
    .DIR(1), .SPEED(4), .DELAY_TICKS(2), .MAX_DIST(0)) u_dn (
    .clk(clk), .rst_n(rst_n), .restart(restart), .update_en(update_en),
    .toggle_en(toggle_en), .kid_x(kid_x), .kid_y(kid_y),
    .triggered(triggered[0]), .pix(b0.slave));

  trap_sprite_mover #(.INIT_X(50), .INIT_Y(50), .NUM_FRAMES(2), .ROM_AW(11),
    .TRIG_X0(200), .TRIG_X1(299), .TRIG_Y0(0), .TRIG_Y1(99),
    .DIR(3), .SPEED(4), .DELAY_TICKS(0), .MAX_DIST(10)) u_rt (
    .clk(clk), .rst_n(rst_n), .restart(restart), .update_en(update_en),
    .toggle_en(toggle_en), .kid_x(kid_x), .kid_y(kid_y),
    .triggered(triggered[1]), .pix(b1.slave));

  trap_sprite_mover #(.INIT_X(10), .INIT_Y(20), .NUM_FRAMES(1), .ROM_AW(11),
    .TRIG_X0(400), .TRIG_X1(499), .TRIG_Y0(0), .TRIG_Y1(99),
    .DIR(0), .SPEED(8), .DELAY_TICKS(0), .MAX_DIST(0)) u_up (
    .clk(clk), .rst_n(rst_n), .restart(restart), .update_en(update_en),
    .toggle_en(toggle_en), .kid_x(kid_x), .kid_y(kid_y),
    .triggered(triggered[2]), .pix(b2.slave));

  typedef struct {
    string       tag;
    int          idx;
    logic        is;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fr[3]    = '{0, 0, 0};
  int   nf[3]    = '{3, 2, 1};
  int   xs_rt[4] = '{54, 58, 60, 60};
  int   ys_up[7] = '{12, 4, -4, -12, -20, -28, -28};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int ea(input int i, input int ox, input int oy);
    return ox + oy * 22 + fr[i] * 528;
  endfunction

  task automatic probe(input string tag, input int i, input int x, input int y,
                       input bit exp_in, input int exp_addr);
    logic [11:0] v;
    exp_t        e, got;
    col = 10'(x);
    row = 10'(y);
    #1;
    chk({tag, "/addr"}, 32'(addr_o[i]), exp_in ? 32'(exp_addr) : 32'd0);
    v     = rom_val(11'(exp_addr));
    e.tag = tag;
    e.idx = i;
    e.is  = exp_in && (v != 12'hFFF);
    e.rgb = e.is ? v : 12'h000;
    sb.push_back(e);
    cyc();
    got = sb.pop_front();
    chk({got.tag, "/is_obj"}, 32'(is_o[got.idx]), 32'(got.is));
    chk({got.tag, "/rgb"}, 32'(rgb_o[got.idx]), 32'(got.rgb));
  endtask

  task automatic upd();
    update_en = 1'b1;
    cyc();
    update_en = 1'b0;
    cyc();
  endtask

  task automatic tog();
    toggle_en = 1'b1;
    cyc();
    toggle_en = 1'b0;
    for (int i = 0; i < 3; i++) fr[i] = (fr[i] + 1) % nf[i];
  endtask

  task automatic kid_pulse(input int x, input int y);
    kid_x = 10'(x);
    kid_y = 10'(y);
    cyc();
    kid_x = 10'd1000;
    kid_y = 10'd1000;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    for (int i = 0; i < 3; i++) fr[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sequence still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; restart = 1'b0; update_en = 1'b0; toggle_en = 1'b0;
    kid_x = 10'd1000; kid_y = 10'd1000; col = 10'd100; row = 10'd0;
    cyc();
    cyc();
    chk("reset_is_obj", 32'(is_o[0]), 32'd0);
    chk("reset_rgb", 32'(rgb_o[0]), 32'd0);
    chk("reset_triggered", 32'(triggered), 32'd0);
    rst_n = 1'b1;
    cyc();

    probe("init_origin", 0, 100, 0, 1, ea(0, 0, 0));
    probe("init_transparent", 0, 103, 0, 1, ea(0, 3, 0));
    probe("init_left_out", 0, 99, 0, 0, 0);
    probe("init_corner", 0, 121, 23, 1, ea(0, 21, 23));
    probe("init_right_out", 0, 122, 0, 0, 0);
    probe("init_below_out", 0, 100, 24, 0, 0);
    probe("rt_init", 1, 50, 50, 1, ea(1, 0, 0));
    probe("up_init", 2, 10, 20, 1, ea(2, 0, 0));

    for (int k = 0; k < 3; k++) begin
      tog();
      probe("frame_dn", 0, 100, 0, 1, ea(0, 0, 0));
      probe("frame_rt", 1, 51, 50, 1, ea(1, 1, 0));
    end

    restart = 1'b1; kid_x = 10'd50; kid_y = 10'd50;
    cyc();
    restart = 1'b0; kid_x = 10'd1000; kid_y = 10'd1000;
    for (int i = 0; i < 3; i++) fr[i] = 0;
    cyc();
    chk("restart_vs_trigger", 32'(triggered), 32'd0);
    probe("restart_frame_rt", 1, 50, 50, 1, ea(1, 0, 0));

    kid_x = 10'd50; kid_y = 10'd50; update_en = 1'b1;
    cyc();
    kid_x = 10'd1000; kid_y = 10'd1000; update_en = 1'b0;
    cyc();
    chk("trigger_dn", 32'(triggered), 32'b001);
    upd();
    upd();
    probe("delay_hold", 0, 100, 0, 1, ea(0, 0, 0));
    for (int k = 1; k <= 150; k++) begin
      upd();
      if (k == 1 || k == 2 || k == 75 || k == 150) begin
        probe("dn_pos", 0, 100, 4 * k, 1, ea(0, 0, 0));
        probe("dn_above_out", 0, 100, 4 * k - 1, 0, 0);
      end
    end
    upd();
    probe("dn_done_hold", 0, 100, 600, 1, ea(0, 0, 0));
    chk("dn_still_triggered", 32'(triggered), 32'b001);

    kid_pulse(250, 50);
    cyc();
    chk("trigger_rt", 32'(triggered), 32'b011);
    for (int k = 0; k < 4; k++) begin
      upd();
      probe("rt_pos", 1, xs_rt[k], 50, 1, ea(1, 0, 0));
      probe("rt_left_out", 1, xs_rt[k] - 1, 50, 0, 0);
    end

    kid_pulse(450, 50);
    cyc();
    chk("trigger_up", 32'(triggered), 32'b111);
    for (int k = 0; k < 7; k++) begin
      upd();
      if (ys_up[k] >= 0) begin
        probe("up_pos", 2, 10, ys_up[k], 1, ea(2, 0, 0));
        probe("up_above_out", 2, 10, ys_up[k] - 1, 0, 0);
      end else begin
        probe("up_partial", 2, 10, 0, (-ys_up[k]) < 24,
              ((-ys_up[k]) < 24) ? ea(2, 0, -ys_up[k]) : 0);
      end
    end

    do_restart();
    chk("restart_clears", 32'(triggered), 32'd0);
    probe("restart_pos_dn", 0, 100, 0, 1, ea(0, 0, 0));

    kid_pulse(50, 50);
    upd();
    upd();
    cyc();
    for (int k = 0; k < 75; k++) upd();
    probe("mid_move_pos", 0, 100, 300, 1, ea(0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_trig", 32'(triggered), 32'd0);
    for (int i = 0; i < 3; i++) fr[i] = 0;
    col = 10'd100; row = 10'd300;
    cyc();
    chk("async_reset_is_obj", 32'(is_o[0]), 32'd0);
    rst_n = 1'b1;
    cyc();
    probe("after_reset_old_pos", 0, 100, 300, 0, 0);
    probe("after_reset_init", 0, 100, 0, 1, ea(0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
